// File: rtl/sc_fibseq_pkg.sv
// Shared encodings and control words for the Fibonacci sequencer.
package sc_fibseq_pkg;

   typedef enum logic [3:0] {
      ST_IDLE   = 4'd0,
      ST_CLEAR0 = 4'd1,
      ST_CLEAR1 = 4'd2,
      ST_INIT1  = 4'd3,
      ST_CHECK  = 4'd4,
      ST_ADD    = 4'd5,
      ST_MOVE0  = 4'd6,
      ST_MOVE1  = 4'd7,
      ST_RESULT = 4'd8,
      ST_DONE   = 4'd9,
      ST_ERROR  = 4'd10
   } state_t;

   localparam logic [2:0] MUX_REG0 = 3'b000;
   localparam logic [2:0] MUX_REG1 = 3'b001;
   localparam logic [2:0] MUX_REG2 = 3'b010;
   localparam logic [2:0] MUX_REG3 = 3'b011;
   localparam logic [2:0] MUX_FIX0 = 3'b100;
   localparam logic [2:0] MUX_FIX1 = 3'b101;
   localparam logic [2:0] MUX_NONE = 3'b111;

   localparam logic [3:0] ALU_PASSA = 4'b0000;
   localparam logic [3:0] ALU_ADD   = 4'b1000;
   localparam logic [3:0] ALU_INC   = 4'b1010;
   localparam logic [3:0] ALU_NOP   = 4'b1111;

   localparam logic [2:0] DEC_NONE = 3'b111;

   // One complete output word per state, including the handshake flags.
   typedef struct packed {
      logic [2:0] clrsel;
      logic [2:0] ldsel;
      logic [2:0] muxa;
      logic [2:0] muxb;
      logic [3:0] alu;
      logic       shclr_n;
      logic       shld_n;
      logic [1:0] shmode;
      logic       busy;
      logic       done;
      logic       error;
   } ctrl_t;

   localparam ctrl_t IDLE_CTRL = '{
      clrsel: DEC_NONE, ldsel: DEC_NONE, muxa: MUX_NONE, muxb: MUX_NONE,
      alu: ALU_NOP, shclr_n: 1'b1, shld_n: 1'b1, shmode: 2'b11,
      busy: 1'b0, done: 1'b0, error: 1'b0};

   function automatic ctrl_t ctrl_word(input state_t s);
      ctrl_t c;
      c = IDLE_CTRL;
      c.busy = !(s inside {ST_IDLE, ST_DONE, ST_ERROR});
      case (s)
         ST_CLEAR0: c.clrsel = MUX_REG0;
         ST_CLEAR1: c.clrsel = MUX_REG1;
         ST_INIT1:  begin c.muxa = MUX_REG0; c.alu = ALU_INC;   c.ldsel = MUX_REG1; end
         ST_ADD:    begin c.muxa = MUX_REG0; c.muxb = MUX_REG1;
                          c.alu = ALU_ADD;   c.ldsel = MUX_REG2; end
         ST_MOVE0:  begin c.muxa = MUX_REG1; c.alu = ALU_PASSA; c.ldsel = MUX_REG0; end
         ST_MOVE1:  begin c.muxa = MUX_REG2; c.alu = ALU_PASSA; c.ldsel = MUX_REG1; end
         ST_RESULT: begin c.muxa = MUX_REG0; c.alu = ALU_PASSA; c.ldsel = MUX_REG3;
                          c.shld_n = 1'b0;   c.shmode = 2'b11; end
         ST_DONE:   c.done  = 1'b1;
         ST_ERROR:  c.error = 1'b1;
         default:   c.busy  = c.busy;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/sc_fibseq_itercounter.sv
// Loadable down-counter holding the iterations still to run.
module sc_fibseq_itercounter #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] value_i,
   input  logic             dec_i,
   output logic [WIDTH-1:0] count_o,
   output logic             zero_o
);

   logic [WIDTH-1:0] count_q;

   // Load has priority; decrement saturates at zero.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         count_q <= '0;
      else if (load_i)
         count_q <= value_i;
      else if (dec_i && (count_q != '0))
         count_q <= count_q - 1'b1;
   end

   assign count_o = count_q;
   assign zero_o  = (count_q == '0);

endmodule

// File: rtl/sc_fibseq_statemachine.sv
// Fibonacci sequencer driving the register/ALU/shifter datapath controls.
module sc_fibseq_statemachine
   import sc_fibseq_pkg::*;
#(
   parameter int unsigned DATAWIDTH_DECODER_SELECTION    = 3,
   parameter int unsigned DATAWIDTH_MUX_SELECTION        = 3,
   parameter int unsigned DATAWIDTH_ALU_SELECTION        = 4,
   parameter int unsigned DATAWIDTH_REGSHIFTER_SELECTION = 2,
   parameter int unsigned DATAWIDTH_ITER                 = 8,
   parameter int unsigned OVF_MODE                       = 0
) (
   input  logic                                      SC_FIBSEQ_CLOCK_50,
   input  logic                                      SC_FIBSEQ_RESET_InHigh,
   input  logic                                      SC_FIBSEQ_start_InHigh,
   input  logic [DATAWIDTH_ITER-1:0]                 SC_FIBSEQ_iterations_InBUS,
   input  logic                                      SC_FIBSEQ_overflow_InLow,
   input  logic                                      SC_FIBSEQ_carry_InLow,
   output logic [DATAWIDTH_DECODER_SELECTION-1:0]    SC_FIBSEQ_decoderclearselection_OutBUS,
   output logic [DATAWIDTH_DECODER_SELECTION-1:0]    SC_FIBSEQ_decoderloadselection_OutBUS,
   output logic [DATAWIDTH_MUX_SELECTION-1:0]        SC_FIBSEQ_muxselectionBUSA_OutBUS,
   output logic [DATAWIDTH_MUX_SELECTION-1:0]        SC_FIBSEQ_muxselectionBUSB_OutBUS,
   output logic [DATAWIDTH_ALU_SELECTION-1:0]        SC_FIBSEQ_aluselection_OutBUS,
   output logic                                      SC_FIBSEQ_regSHIFTERclear_OutLow,
   output logic                                      SC_FIBSEQ_regSHIFTERload_OutLow,
   output logic [DATAWIDTH_REGSHIFTER_SELECTION-1:0] SC_FIBSEQ_regSHIFTERshiftselection_OutLow,
   output logic                                      SC_FIBSEQ_busy_OutHigh,
   output logic                                      SC_FIBSEQ_done_OutHigh,
   output logic                                      SC_FIBSEQ_error_OutHigh,
   output logic [DATAWIDTH_ITER-1:0]                 SC_FIBSEQ_remaining_OutBUS
);

   state_t state_q, state_d;
   logic   pending_q, pending_d;
   ctrl_t  ctrl_d;
   logic   flag_n;
   logic   rem_zero;
   logic   rem_load;
   logic   rem_dec;

   assign flag_n   = (OVF_MODE != 0) ? SC_FIBSEQ_overflow_InLow : SC_FIBSEQ_carry_InLow;
   assign rem_load = (state_q == ST_IDLE) && SC_FIBSEQ_start_InHigh;
   assign rem_dec  = (state_q == ST_MOVE1);

   sc_fibseq_itercounter #(
      .WIDTH (DATAWIDTH_ITER)
   ) u_itercounter (
      .clk_i   (SC_FIBSEQ_CLOCK_50),
      .rst_i   (SC_FIBSEQ_RESET_InHigh),
      .load_i  (rem_load),
      .value_i (SC_FIBSEQ_iterations_InBUS),
      .dec_i   (rem_dec),
      .count_o (SC_FIBSEQ_remaining_OutBUS),
      .zero_o  (rem_zero)
   );

   // Next-state and overflow-pending logic.
   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      case (state_q)
         ST_IDLE:   if (SC_FIBSEQ_start_InHigh) begin
                       state_d   = ST_CLEAR0;
                       pending_d = 1'b0;
                    end
         ST_CLEAR0: state_d = ST_CLEAR1;
         ST_CLEAR1: state_d = ST_INIT1;
         ST_INIT1:  state_d = ST_CHECK;
         // An overflow on the last ADD is harmless: REG0 already holds the answer.
         ST_CHECK:  if (rem_zero)       state_d = ST_RESULT;
                    else if (pending_q) state_d = ST_ERROR;
                    else                state_d = ST_ADD;
         ST_ADD:    begin
                       pending_d = !flag_n;
                       state_d   = ST_MOVE0;
                    end
         ST_MOVE0:  state_d = ST_MOVE1;
         ST_MOVE1:  state_d = ST_CHECK;
         ST_RESULT: state_d = ST_DONE;
         ST_DONE:   state_d = ST_IDLE;
         ST_ERROR:  if (SC_FIBSEQ_start_InHigh) state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
      ctrl_d = ctrl_word(state_d);
   end

   // State register with outputs registered from the decoded next state, so
   // each output word always matches the state it belongs to.
   always_ff @(posedge SC_FIBSEQ_CLOCK_50 or posedge SC_FIBSEQ_RESET_InHigh) begin
      if (SC_FIBSEQ_RESET_InHigh) begin
         state_q   <= ST_IDLE;
         pending_q <= 1'b0;
         SC_FIBSEQ_decoderclearselection_OutBUS    <= '1;
         SC_FIBSEQ_decoderloadselection_OutBUS     <= '1;
         SC_FIBSEQ_muxselectionBUSA_OutBUS         <= '1;
         SC_FIBSEQ_muxselectionBUSB_OutBUS         <= '1;
         SC_FIBSEQ_aluselection_OutBUS             <= '1;
         SC_FIBSEQ_regSHIFTERclear_OutLow          <= 1'b1;
         SC_FIBSEQ_regSHIFTERload_OutLow           <= 1'b1;
         SC_FIBSEQ_regSHIFTERshiftselection_OutLow <= '1;
         SC_FIBSEQ_busy_OutHigh                    <= 1'b0;
         SC_FIBSEQ_done_OutHigh                    <= 1'b0;
         SC_FIBSEQ_error_OutHigh                   <= 1'b0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         SC_FIBSEQ_decoderclearselection_OutBUS    <= DATAWIDTH_DECODER_SELECTION'(ctrl_d.clrsel);
         SC_FIBSEQ_decoderloadselection_OutBUS     <= DATAWIDTH_DECODER_SELECTION'(ctrl_d.ldsel);
         SC_FIBSEQ_muxselectionBUSA_OutBUS         <= DATAWIDTH_MUX_SELECTION'(ctrl_d.muxa);
         SC_FIBSEQ_muxselectionBUSB_OutBUS         <= DATAWIDTH_MUX_SELECTION'(ctrl_d.muxb);
         SC_FIBSEQ_aluselection_OutBUS             <= DATAWIDTH_ALU_SELECTION'(ctrl_d.alu);
         SC_FIBSEQ_regSHIFTERclear_OutLow          <= ctrl_d.shclr_n;
         SC_FIBSEQ_regSHIFTERload_OutLow           <= ctrl_d.shld_n;
         SC_FIBSEQ_regSHIFTERshiftselection_OutLow <= DATAWIDTH_REGSHIFTER_SELECTION'(ctrl_d.shmode);
         SC_FIBSEQ_busy_OutHigh                    <= ctrl_d.busy;
         SC_FIBSEQ_done_OutHigh                    <= ctrl_d.done;
         SC_FIBSEQ_error_OutHigh                   <= ctrl_d.error;
      end
   end

endmodule

// File: tb/tb_sc_fibseq_statemachine.sv
// Bench for the Fibonacci sequencer with a small 8-bit datapath model.
module tb_sc_fibseq_statemachine;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [7:0] iter = '0;
   logic       ovf_n, carry_n;
   logic [2:0] clrsel, ldsel, muxa, muxb;
   logic [3:0] alu;
   logic       shclr_n, shld_n;
   logic [1:0] shmode;
   logic       busy, done, err;
   logic [7:0] rem;

   int unsigned tests = 0;
   int unsigned fails = 0;

   sc_fibseq_statemachine #(
      .DATAWIDTH_DECODER_SELECTION    (3),
      .DATAWIDTH_MUX_SELECTION        (3),
      .DATAWIDTH_ALU_SELECTION        (4),
      .DATAWIDTH_REGSHIFTER_SELECTION (2),
      .DATAWIDTH_ITER                 (8),
      .OVF_MODE                       (0)
   ) dut (
      .SC_FIBSEQ_CLOCK_50                        (clk),
      .SC_FIBSEQ_RESET_InHigh                    (rst),
      .SC_FIBSEQ_start_InHigh                    (start),
      .SC_FIBSEQ_iterations_InBUS                (iter),
      .SC_FIBSEQ_overflow_InLow                  (ovf_n),
      .SC_FIBSEQ_carry_InLow                     (carry_n),
      .SC_FIBSEQ_decoderclearselection_OutBUS    (clrsel),
      .SC_FIBSEQ_decoderloadselection_OutBUS     (ldsel),
      .SC_FIBSEQ_muxselectionBUSA_OutBUS         (muxa),
      .SC_FIBSEQ_muxselectionBUSB_OutBUS         (muxb),
      .SC_FIBSEQ_aluselection_OutBUS             (alu),
      .SC_FIBSEQ_regSHIFTERclear_OutLow          (shclr_n),
      .SC_FIBSEQ_regSHIFTERload_OutLow           (shld_n),
      .SC_FIBSEQ_regSHIFTERshiftselection_OutLow (shmode),
      .SC_FIBSEQ_busy_OutHigh                    (busy),
      .SC_FIBSEQ_done_OutHigh                    (done),
      .SC_FIBSEQ_error_OutHigh                   (err),
      .SC_FIBSEQ_remaining_OutBUS                (rem)
   );

   always #5 clk = ~clk;

   // Datapath model: four general registers, a shifter register and an ALU.
   logic [7:0] regs [4];
   logic [7:0] shreg;
   logic [7:0] bus_a, bus_b, alu_res;
   logic       alu_c, alu_v;

   function automatic logic [7:0] mux_val(input logic [2:0] sel);
      case (sel)
         3'b000, 3'b001, 3'b010, 3'b011: return regs[sel[1:0]];
         3'b101:  return 8'd1;
         default: return 8'd0;
      endcase
   endfunction

   always_comb begin
      bus_a   = mux_val(muxa);
      bus_b   = mux_val(muxb);
      alu_res = 8'd0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      case (alu)
         4'b0000: alu_res = bus_a;
         4'b1000: begin
            {alu_c, alu_res} = {1'b0, bus_a} + {1'b0, bus_b};
            alu_v = (bus_a[7] == bus_b[7]) && (alu_res[7] != bus_a[7]);
         end
         4'b1010: {alu_c, alu_res} = {1'b0, bus_a} + 9'd1;
         default: alu_res = 8'd0;
      endcase
      carry_n = ~alu_c;
      ovf_n   = ~alu_v;
   end

   always @(posedge clk) begin
      if (clrsel[2] == 1'b0) regs[clrsel[1:0]] <= 8'd0;
      if (ldsel[2] == 1'b0)  regs[ldsel[1:0]]  <= alu_res;
      if (!shclr_n)          shreg <= 8'd0;
      else if (!shld_n)      shreg <= alu_res;
   end

   // Scoreboard entries describe the expected end of each run.
   typedef struct {
      logic        err;
      logic [7:0]  res;
      int unsigned lat;
      logic [7:0]  rem;
   } exp_t;
   exp_t sb[$];

   // Reference: Fib(n) on an 8-bit unsigned datapath; a carry on any
   // iteration but the last aborts the run.
   function automatic exp_t model(input int unsigned n);
      exp_t e;
      int unsigned a, b, s;
      a = 0; b = 1;
      e.err = 1'b0; e.res = 8'd0; e.lat = 4 * n + 6; e.rem = 8'd0;
      for (int unsigned k = 1; k <= n; k++) begin
         s = a + b;
         if (s > 255 && k < n) begin
            e.err = 1'b1;
            e.lat = 4 * k + 5;
            e.rem = 8'(n - k);
            return e;
         end
         a = b;
         b = s % 256;
      end
      e.res = 8'(a);
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [19:0] ctrl_bus();
      return {clrsel, ldsel, muxa, muxb, alu, shclr_n, shld_n, shmode};
   endfunction

   // One run: start sampled on edge 1, then count edges until done or error.
   task automatic run(input int unsigned n, input bit poke);
      exp_t        e;
      int unsigned edges;
      sb.push_back(model(n));
      @(negedge clk);
      iter  = 8'(n);
      start = 1'b1;
      @(posedge clk);
      edges = 1;
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_start", {31'd0, busy}, 32'd1);
      chk("rem_loaded", {24'd0, rem}, n);
      while (!done && !err && edges < 1000) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
         if (poke && edges == 12) chk("rem_after_poke", {24'd0, rem}, n - 2);
         if (poke && edges == 10) begin
            start = 1'b1;
            iter  = 8'd200;
         end else begin
            start = 1'b0;
         end
      end
      chk("sb_nonempty", {31'd0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) begin
         e = sb.pop_front();
         chk("latency", edges, e.lat);
         chk("error_flag", {31'd0, err}, {31'd0, e.err});
         chk("remaining_end", {24'd0, rem}, {24'd0, e.rem});
         chk("busy_end", {31'd0, busy}, 32'd0);
         if (!e.err) begin
            chk("reg3_result", {24'd0, regs[3]}, {24'd0, e.res});
            chk("shifter_result", {24'd0, shreg}, {24'd0, e.res});
            @(negedge clk);
            chk("done_one_cycle", {31'd0, done}, 32'd0);
         end
      end
   endtask

   initial begin
      int unsigned guard;
      #12;
      chk("reset_ctrl_word", {12'd0, ctrl_bus()}, 32'hFFFFF);
      chk("reset_flags", {29'd0, busy, done, err}, 32'd0);
      chk("reset_remaining", {24'd0, rem}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      run(0, 1'b0);
      run(1, 1'b0);
      run(2, 1'b0);
      run(10, 1'b0);
      run(12, 1'b0);
      run(13, 1'b0);
      run(5, 1'b1);

      // Overflow abort: error holds, next start only returns to idle.
      run(14, 1'b0);
      repeat (3) @(negedge clk);
      chk("error_sticky", {31'd0, err}, 32'd1);
      chk("error_ctrl_word", {12'd0, ctrl_bus()}, 32'hFFFFF);
      iter  = 8'd3;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("error_cleared", {31'd0, err}, 32'd0);
      repeat (2) @(negedge clk);
      chk("start_consumed_busy", {31'd0, busy}, 32'd0);
      chk("start_consumed_rem", {24'd0, rem}, 32'd1);

      // Asynchronous reset while the ALU is adding.
      iter  = 8'd10;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      guard = 0;
      while (alu !== 4'b1000 && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      chk("reached_add", {28'd0, alu}, 32'h8);
      #2 rst = 1'b1;
      #1;
      chk("async_reset_ctrl", {12'd0, ctrl_bus()}, 32'hFFFFF);
      chk("async_reset_busy", {31'd0, busy}, 32'd0);
      chk("async_reset_rem", {24'd0, rem}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      run(7, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/sc_fibseq_statemachine.md
Name: sc_fibseq_statemachine

Overview:
- Parametrised control sequencer for the register/ALU/shifter datapath.
- Computes Fib(N) for a run-time iteration count N on the datapath's general registers, using the existing decoder, mux, ALU and shifter control buses.
- Adds behaviour the fixed-sequence machines lack: a start/busy/done handshake, a loop counter driven by a data-dependent branch, and overflow abort from the ALU flags.
- Sits between the top-level controls and the datapath, in place of the fixed-sequence state machine.

Parameters:
- DATAWIDTH_DECODER_SELECTION, 3, width of the clear/load decoder selection buses.
- DATAWIDTH_MUX_SELECTION, 3, width of the BUSA/BUSB mux selection buses.
- DATAWIDTH_ALU_SELECTION, 4, width of the ALU operation bus.
- DATAWIDTH_REGSHIFTER_SELECTION, 2, width of the shifter mode bus.
- DATAWIDTH_ITER, 8, width of the iteration count.
- OVF_MODE, 0, overflow source: 0 = carry_InLow (unsigned); 1 = overflow_InLow (signed).

Ports:
- SC_FIBSEQ_CLOCK_50  in  1  single clock, rising edge.
- SC_FIBSEQ_RESET_InHigh  in  1  reset, asynchronous, active-high.
- SC_FIBSEQ_start_InHigh  in  1  start request.
- SC_FIBSEQ_iterations_InBUS  in  DATAWIDTH_ITER  N, sampled on start.
- SC_FIBSEQ_overflow_InLow  in  1  ALU signed overflow, active-low.
- SC_FIBSEQ_carry_InLow  in  1  ALU carry, active-low.
- SC_FIBSEQ_decoderclearselection_OutBUS  out  DATAWIDTH_DECODER_SELECTION  general register to clear.
- SC_FIBSEQ_decoderloadselection_OutBUS  out  DATAWIDTH_DECODER_SELECTION  general register to load.
- SC_FIBSEQ_muxselectionBUSA_OutBUS  out  DATAWIDTH_MUX_SELECTION  BUSA source.
- SC_FIBSEQ_muxselectionBUSB_OutBUS  out  DATAWIDTH_MUX_SELECTION  BUSB source.
- SC_FIBSEQ_aluselection_OutBUS  out  DATAWIDTH_ALU_SELECTION  ALU operation.
- SC_FIBSEQ_regSHIFTERclear_OutLow  out  1  shifter clear.
- SC_FIBSEQ_regSHIFTERload_OutLow  out  1  shifter load.
- SC_FIBSEQ_regSHIFTERshiftselection_OutLow  out  DATAWIDTH_REGSHIFTER_SELECTION  shifter mode.
- SC_FIBSEQ_busy_OutHigh  out  1  high in every state except IDLE, DONE and ERROR.
- SC_FIBSEQ_done_OutHigh  out  1  one-cycle pulse, result valid.
- SC_FIBSEQ_error_OutHigh  out  1  sticky overflow abort.
- SC_FIBSEQ_remaining_OutBUS  out  DATAWIDTH_ITER  iterations still to run.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- Reset → IDLE; remaining=0, pending=0, error=0, done=0, busy=0.
- Idle control word: decoders 111, muxes 111, ALU 1111, shifter clear=1, load=1, mode 11. Driven in IDLE, DONE, ERROR and default.
- Moore outputs, fully decoded from the state register. Flags are sampled only at clock edges.
- Register use: REG0=a, REG1=b, REG2=temp, REG3=result.
- IDLE: start=1 → CLEAR0, and remaining ← iterations_InBUS. Start is ignored in all other states.
- CLEAR0: clear selection 000 → CLEAR1.
- CLEAR1: clear selection 001 → INIT1.
- INIT1: BUSA=000, ALU 1010 (INC), load 001 → CHECK. Result: REG1=1.
- CHECK, no bus activity:
  - remaining==0 → RESULT.
  - else pending==1 → ERROR.
  - else → ADD.
- ADD: BUSA=000, BUSB=001, ALU 1000, load 010 → MOVE0. At this edge, pending ← (selected flag==0).
- MOVE0: BUSA=001, ALU 0000, load 000 → MOVE1.
- MOVE1: BUSA=010, ALU 0000, load 001; remaining ← remaining−1 → CHECK.
- RESULT: BUSA=000, ALU 0000, load 011, shifter load=0, mode 11 → DONE.
- DONE: done=1 for exactly one cycle → IDLE.
- ERROR: error=1 and held; returns to IDLE on start=1. That start is consumed: it clears error but does not begin a run.
- Latency: DONE is entered on the (4N+6)th edge after the edge that sampled start. Example: N=0 → 6 edges.
- Overflow on the final iteration does not abort, because a (REG0) is still correct. This gives Fib(N) for all N up to the datapath limit.
- remaining never underflows; decrement occurs only when it is nonzero.
- Reset mid-run: immediate return to IDLE with the idle control word. Datapath register contents are not restored.
- Unused state encodings → IDLE on the next edge.

Decomposition:
- Shared package sc_fibseq_pkg holds:
  - state encodings;
  - the idle control word;
  - mux codes (REG0..REG3 = 000..011, FIX0 = 100, FIX1 = 101, NONE = 111);
  - ALU codes (PASSA 0000, ADD 1000, INC 1010, NOP 1111);
  - decoder NONE = 111.
- One sub-module: sc_fibseq_itercounter. Loadable down-counter with load, decrement enable and zero flag, width DATAWIDTH_ITER.

Test Plan:
- Reset asserted mid-ADD: outputs go to the idle word asynchronously, before the next edge; busy=0, remaining=0.
- start, N=0 on an 8-bit datapath: DONE on edge 6; REG3=0; error=0.
- start, N=10: done pulses once on edge 46; REG3=55; the shifter load-low strobe appears in RESULT.
- N=13, OVF_MODE=0: carry on the last ADD; DONE, REG3=233, error=0.
- N=14, OVF_MODE=0: carry on ADD of iteration 13 → ERROR with remaining=1; error stays high; the next start returns to IDLE.
- start pulsed again while busy: ignored; remaining and timing unchanged.
